// File: rtl/sopc_run_ctrl.sv
`timescale 1ns/1ps
// sopc_run_ctrl: holds all core domains in reset after rst, releases them
// one by one on a fixed stagger, runs for a bounded number of cycles, then
// stops with every domain back in reset until a restart request.

// Per-domain release decode: high once the sequence edge count reaches
// this domain's release edge.
module sopc_run_dom #(
  parameter int SEQ_W    = 4,
  parameter int REL_EDGE = 1
) (
  input  logic [SEQ_W-1:0] edge_i,
  output logic             rel_o
);
  localparam logic [SEQ_W-1:0] REL = SEQ_W'(REL_EDGE);
  assign rel_o = (edge_i >= REL);
endmodule

module sopc_run_ctrl #(
  parameter int NUM_DOM     = 2,
  parameter int HOLD_CYCLES = 10,
  parameter int STAGGER     = 2,
  parameter int RUN_CYCLES  = 50,
  parameter int CNT_W       = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               halt_req,
  input  logic               restart,
  output logic [NUM_DOM-1:0] dom_rst,
  output logic [CNT_W-1:0]   cycle_cnt,
  output logic               running,
  output logic               stopped,
  output logic               timeout
);
  typedef enum logic [1:0] {S_HOLD, S_RELEASE, S_RUN, S_STOP} state_e;

  // Release edge of domain d, counted from the first edge after rst/restart;
  // edge 1 is the earliest any domain can leave reset.
  function automatic int rel_edge(input int d);
    int e;
    e = HOLD_CYCLES + d * STAGGER;
    return (e < 1) ? 1 : e;
  endfunction

  localparam int HOLD_END = (HOLD_CYCLES < 1) ? 1 : HOLD_CYCLES;
  localparam int LAST_REL = rel_edge(NUM_DOM - 1);
  // Sequence counter stops at LAST_REL, so it never needs to wrap.
  localparam int SEQ_W    = $clog2(LAST_REL + 2);
  localparam logic [SEQ_W-1:0] HOLD_END_V = SEQ_W'(HOLD_END);
  localparam logic [SEQ_W-1:0] LAST_REL_V = SEQ_W'(LAST_REL);
  localparam logic [63:0]      RUN_LIM    = 64'(RUN_CYCLES);

  state_e               state_q, state_d;
  logic [SEQ_W-1:0]     seq_q, seq_d, edge_nxt;
  logic [NUM_DOM-1:0]   dom_rst_q, dom_rst_d, rel;
  logic [CNT_W-1:0]     cycle_cnt_q, cycle_cnt_d, cnt_inc;
  logic                 running_q, running_d;
  logic                 stopped_q, stopped_d;
  logic                 timeout_q, timeout_d;

  assign edge_nxt = seq_q + SEQ_W'(1);
  assign cnt_inc  = (cycle_cnt_q == '1) ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);

  for (genvar g = 0; g < NUM_DOM; g++) begin : g_dom
    sopc_run_dom #(.SEQ_W(SEQ_W), .REL_EDGE(rel_edge(g))) u_dom (
      .edge_i (edge_nxt),
      .rel_o  (rel[g])
    );
  end

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_d     = state_q;
    seq_d       = seq_q;
    dom_rst_d   = dom_rst_q;
    cycle_cnt_d = cycle_cnt_q;
    running_d   = running_q;
    stopped_d   = stopped_q;
    timeout_d   = timeout_q;
    case (state_q)
      S_HOLD, S_RELEASE: begin
        seq_d     = edge_nxt;
        dom_rst_d = dom_rst_q & ~rel;
        if (edge_nxt >= LAST_REL_V) begin
          state_d     = S_RUN;
          dom_rst_d   = '0;
          running_d   = 1'b1;
          cycle_cnt_d = '0;
        end else if (edge_nxt >= HOLD_END_V) begin
          state_d = S_RELEASE;
        end
      end
      S_RUN: begin
        cycle_cnt_d = cnt_inc;
        // Halt has priority, so a halt on the expiry edge leaves timeout low.
        if (halt_req) begin
          state_d   = S_STOP;
          dom_rst_d = '1;
          running_d = 1'b0;
          stopped_d = 1'b1;
          timeout_d = 1'b0;
        end else if ((RUN_CYCLES != 0) && (64'(cnt_inc) == RUN_LIM)) begin
          state_d   = S_STOP;
          dom_rst_d = '1;
          running_d = 1'b0;
          stopped_d = 1'b1;
          timeout_d = 1'b1;
        end
      end
      S_STOP: begin
        // The restart edge is edge 0 of the new sequence.
        if (restart) begin
          state_d     = S_HOLD;
          seq_d       = '0;
          dom_rst_d   = '1;
          cycle_cnt_d = '0;
          stopped_d   = 1'b0;
          timeout_d   = 1'b0;
        end
      end
      default: state_d = S_HOLD;
    endcase
  end

  // State and registered outputs; rst low forces the fresh-sequence state.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_HOLD;
      seq_q       <= '0;
      dom_rst_q   <= '1;
      cycle_cnt_q <= '0;
      running_q   <= 1'b0;
      stopped_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      seq_q       <= seq_d;
      dom_rst_q   <= dom_rst_d;
      cycle_cnt_q <= cycle_cnt_d;
      running_q   <= running_d;
      stopped_q   <= stopped_d;
      timeout_q   <= timeout_d;
    end
  end

  assign dom_rst   = dom_rst_q;
  assign cycle_cnt = cycle_cnt_q;
  assign running   = running_q;
  assign stopped   = stopped_q;
  assign timeout   = timeout_q;
endmodule
